prbs31_checker: RTL and testbench

// Receive-side checker for the PRBS31 (x^31 + x^28 + 1) serial test stream produced by our PRBS31 generator.

---
 rtl/prbs31_pkg.sv | 19 +
 rtl/prbs31_checker_if.sv | 21 ++
 rtl/prbs31_err_window.sv | 44 ++++
 rtl/prbs31_checker.sv | 124 ++++++++++++
 tb/tb_prbs31_checker.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs31_pkg.sv
// Shared PRBS31 definitions used by both the generator and the checker.
package prbs31_pkg;

    localparam int PRBS_LEN = 31;
    localparam int TAP_A    = 30;
    localparam int TAP_B    = 27;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } prbs_state_t;

    // Next stream bit predicted from the last 31 bits (h[0] newest).
    function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] h);
        return h[TAP_A] ^ h[TAP_B];
    endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial stream and status bundle between a bit source and the PRBS31 checker.
interface prbs31_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output bit_in, bit_valid, clr_cnt,
        input  locked, err_pulse, err_count
    );

    modport slave (
        input  bit_in, bit_valid, clr_cnt,
        output locked, err_pulse, err_count
    );
endinterface

// File: rtl/prbs31_err_window.sv
// Counts errors inside a sliding observation window while locked and flags
// the error that brings the window total up to the loss-of-lock limit.
module prbs31_err_window #(
    parameter int WINDOW    = 1024,
    parameter int ERR_LIMIT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic bit_stb,
    input  logic err_stb,
    output logic limit_hit
);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);

    logic [WW-1:0] win_q;
    logic [EW-1:0] werr_q;
    logic          wrap;
    logic [EW-1:0] werr_base;
    logic [EW-1:0] werr_next;

    // A bit arriving with the window full starts a new window and counts there.
    always_comb begin
        wrap      = (win_q == WW'(WINDOW - 1));
        werr_base = wrap ? '0 : werr_q;
        werr_next = werr_base + EW'(err_stb);
        limit_hit = err_stb && (werr_next == EW'(ERR_LIMIT));
    end

    // Window position and error tally advance only on valid bits while locked.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            win_q  <= '0;
            werr_q <= '0;
        end else if (clear) begin
            win_q  <= '0;
            werr_q <= '0;
        end else if (bit_stb) begin
            win_q  <= wrap ? '0 : win_q + 1'b1;
            werr_q <= werr_next;
        end
    end
endmodule

// File: rtl/prbs31_checker.sv
// Receive-side PRBS31 checker: self-synchronises a predictor to the incoming
// stream, declares lock, then flywheels and counts bit errors.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 1024,
    parameter int ERR_LIMIT = 32,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              rst_n,
    prbs31_checker_if.slave  bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int FW = $clog2(PRBS_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    prbs_state_t         state_q, state_d;
    logic [PRBS_LEN-1:0] h_q, h_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [MW-1:0]       match_q, match_d;
    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                err_pulse_q;
    logic                pred;
    logic                bit_stb;
    logic                bit_err;
    logic                lock_entry;
    logic                limit_hit;

    assign pred    = prbs_predict(h_q);
    assign bit_stb = bus.bit_valid && (state_q == LOCKED);
    assign bit_err = bit_stb && (bus.bit_in != pred);

    prbs31_err_window #(
        .WINDOW    (WINDOW),
        .ERR_LIMIT (ERR_LIMIT)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (lock_entry),
        .bit_stb   (bit_stb),
        .err_stb   (bit_err),
        .limit_hit (limit_hit)
    );

    // Acquisition and tracking FSM; the predictor self-syncs until lock, then flywheels.
    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        fill_d     = fill_q;
        match_d    = match_q;
        lock_entry = 1'b0;
        if (bus.bit_valid) begin
            case (state_q)
                SEARCH: begin
                    h_d = {h_q[PRBS_LEN-2:0], bus.bit_in};
                    if (fill_q == FW'(PRBS_LEN - 1)) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = VERIFY;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                VERIFY: begin
                    h_d = {h_q[PRBS_LEN-2:0], bus.bit_in};
                    if ((bus.bit_in == pred) && (h_q != '0)) begin
                        match_d = match_q + 1'b1;
                        if (match_q == MW'(LOCK_CNT - 1)) begin
                            state_d    = LOCKED;
                            lock_entry = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    h_d = {h_q[PRBS_LEN-2:0], pred};
                    if (limit_hit) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Saturating error counter; a clear on an erroring bit leaves that error counted.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.clr_cnt) begin
            err_count_d = bit_err ? CNT_W'(1) : '0;
        end else if (bit_err && (err_count_q != CNT_MAX)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // State, predictor and counter registers with immediate return to idle on reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= SEARCH;
            h_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            err_count_q <= err_count_d;
            err_pulse_q <= bit_err;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_prbs31_checker.sv
// Randomised self-checking bench for prbs31_checker against a bit-level
// reference model of acquisition, windowed loss of lock and error counting.
module tb_prbs31_checker;
    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 1024;
    localparam int ERR_LIMIT = 32;
    localparam int CNT_W     = 16;
    localparam int SAT_W     = 2;
    localparam int ACQ_BITS  = 31 + LOCK_CNT;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int SAT_MAX   = (1 << SAT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Transmitted stream history, oldest first; s[n] = s[n-31] ^ s[n-28].
    bit hist[$];

    // Reference model state.
    bit m_locked;
    bit m_pulse;
    int m_acq;
    int m_idx;
    int m_win;
    int m_werr;
    int m_count;

    prbs31_checker_if #(.CNT_W(CNT_W)) bus();
    prbs31_checker_if #(.CNT_W(SAT_W)) sat_bus();

    assign sat_bus.bit_in    = bus.bit_in;
    assign sat_bus.bit_valid = bus.bit_valid;
    assign sat_bus.clr_cnt   = bus.clr_cnt;

    prbs31_checker #(
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    prbs31_checker #(
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_LIMIT(ERR_LIMIT), .CNT_W(SAT_W)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(sat_bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one cycle. mode 0 = PRBS stream, 1 = constant 0, 2 = constant 1.
    // Errors are injected only while the model is locked.
    task automatic drive(input bit valid, input int mode, input bit flip, input bit clr);
        bit sb;
        bit err;
        @(negedge clk);
        err = 1'b0;
        if (valid && mode == 0) begin
            sb = hist[0] ^ hist[3];
            hist.push_back(sb);
            void'(hist.pop_front());
            err = flip && m_locked;
            bus.bit_in = sb ^ err;
        end else if (valid) begin
            bus.bit_in = (mode == 2);
        end else begin
            bus.bit_in = 1'($urandom_range(0, 1));
        end
        bus.bit_valid = valid;
        bus.clr_cnt   = clr;
        m_pulse = 1'b0;
        if (clr) m_count = 0;
        if (valid && mode == 0) begin
            if (m_locked) begin
                // The lock-entry edge occupies window slot 0, so windows close at idx+1 multiples.
                if ((m_idx + 1) / WINDOW != m_win) begin
                    m_win  = (m_idx + 1) / WINDOW;
                    m_werr = 0;
                end
                m_idx++;
                if (err) begin
                    m_pulse = 1'b1;
                    if (m_count < CNT_MAX) m_count++;
                    m_werr++;
                    if (m_werr == ERR_LIMIT) begin
                        m_locked = 1'b0;
                        m_acq    = 0;
                    end
                end
            end else begin
                m_acq++;
                if (m_acq == ACQ_BITS) begin
                    m_locked = 1'b1;
                    m_idx    = 0;
                    m_win    = 0;
                    m_werr   = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.bit_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        bus.bit_in    = 1'b0;
        m_locked = 1'b0;
        m_pulse  = 1'b0;
        m_acq    = 0;
        m_idx    = 0;
        m_win    = 0;
        m_werr   = 0;
        m_count  = 0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== '0 || sat_bus.err_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got locked=%0b pulse=%0b cnt=%0d sat=%0d exp all 0",
                     bus.locked, bus.err_pulse, bus.err_count, sat_bus.err_count);
        end
        do_reset();
    endtask

    task automatic test_clean_lock();
        do_reset();
        for (int n = 1; n <= 2000; n++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            checks++;
            if (bus.locked !== 1'(n >= ACQ_BITS)) begin
                errors++;
                $display("[TB] FAIL clean_lock bit %0d got %0b exp %0b", n, bus.locked, n >= ACQ_BITS);
            end
            checks++;
            if (bus.err_pulse !== 1'b0 || bus.err_count !== '0) begin
                errors++;
                $display("[TB] FAIL clean_errors bit %0d got pulse=%0b cnt=%0d exp 0/0", n, bus.err_pulse, bus.err_count);
            end
        end
    endtask

    task automatic test_single_error();
        drive(1'b1, 0, 1'b1, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b1 || bus.err_count !== CNT_W'(1) || bus.locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_err got pulse=%0b cnt=%0d locked=%0b exp 1/1/1", bus.err_pulse, bus.err_count, bus.locked);
        end
        for (int n = 0; n < 31; n++) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            checks++;
            if (bus.err_pulse !== 1'b0 || bus.err_count !== CNT_W'(1) || bus.locked !== 1'b1) begin
                errors++;
                $display("[TB] FAIL flywheel bit %0d got pulse=%0b cnt=%0d locked=%0b exp 0/1/1", n, bus.err_pulse, bus.err_count, bus.locked);
            end
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (bus.err_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pulse_idle got %0b exp 0", bus.err_pulse);
        end
    endtask

    task automatic test_loss_of_lock();
        int vbits;
        do_reset();
        repeat (ACQ_BITS) drive(1'b1, 0, 1'b0, 1'b0);
        for (int k = 1; k <= ERR_LIMIT; k++) begin
            repeat ($urandom_range(0, 19)) drive(1'b1, 0, 1'b0, 1'b0);
            drive(1'b1, 0, 1'b1, 1'b0);
            checks++;
            if (bus.locked !== 1'(k < ERR_LIMIT) || bus.err_pulse !== 1'b1 || bus.err_count !== CNT_W'(k)) begin
                errors++;
                $display("[TB] FAIL burst_err %0d got locked=%0b pulse=%0b cnt=%0d exp %0b/1/%0d",
                         k, bus.locked, bus.err_pulse, bus.err_count, k < ERR_LIMIT, k);
            end
        end
        vbits = 0;
        while (bus.locked !== 1'b1 && vbits < 200) begin
            drive(1'b1, 0, 1'b0, 1'b0);
            vbits++;
        end
        checks++;
        if (vbits != ACQ_BITS || bus.err_count !== CNT_W'(ERR_LIMIT)) begin
            errors++;
            $display("[TB] FAIL relock got %0d bits cnt=%0d exp %0d bits cnt=%0d", vbits, bus.err_count, ACQ_BITS, ERR_LIMIT);
        end
    endtask

    task automatic test_window_boundary();
        bit f;
        do_reset();
        repeat (ACQ_BITS) drive(1'b1, 0, 1'b0, 1'b0);
        // 31 errors closing the first window, then 5 opening the next.
        for (int i = 0; i < 1100; i++) begin
            f = (i >= WINDOW - 32) && (i <= WINDOW + 3);
            drive(1'b1, 0, f, 1'b0);
            checks++;
            if (bus.locked !== 1'b1 || bus.err_pulse !== f || bus.err_count !== CNT_W'(m_count)) begin
                errors++;
                $display("[TB] FAIL window_hold idx %0d got locked=%0b pulse=%0b cnt=%0d exp 1/%0b/%0d",
                         i, bus.locked, bus.err_pulse, bus.err_count, f, m_count);
            end
        end
        checks++;
        if (bus.err_count !== CNT_W'(36)) begin
            errors++;
            $display("[TB] FAIL window_total got %0d exp 36", bus.err_count);
        end
    endtask

    task automatic test_const_input();
        int vcnt;
        bit v;
        for (int m = 1; m <= 2; m++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                drive(1'b1, m, 1'b0, 1'b0);
                checks++;
                if (bus.locked !== 1'b0 || bus.err_count !== '0) begin
                    errors++;
                    $display("[TB] FAIL const_%0d bit %0d got locked=%0b cnt=%0d exp 0/0", m - 1, n, bus.locked, bus.err_count);
                end
            end
        end
        do_reset();
        vcnt = 0;
        for (int c = 0; c < 800 && vcnt < ACQ_BITS + 5; c++) begin
            v = 1'($urandom_range(0, 1));
            drive(v, 0, 1'b0, 1'b0);
            if (v) vcnt++;
            checks++;
            if (bus.locked !== 1'(vcnt >= ACQ_BITS)) begin
                errors++;
                $display("[TB] FAIL sparse_lock valid %0d got %0b exp %0b", vcnt, bus.locked, vcnt >= ACQ_BITS);
            end
        end
        checks++;
        if (vcnt < ACQ_BITS + 5) begin
            errors++;
            $display("[TB] FAIL sparse_budget got %0d valid bits exp %0d", vcnt, ACQ_BITS + 5);
        end
    endtask

    task automatic test_random_errors();
        bit v, f, c;
        int sat_exp;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            v = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 199) == 0);
            drive(v, 0, f, c);
            sat_exp = (m_count > SAT_MAX) ? SAT_MAX : m_count;
            checks++;
            if (bus.locked !== m_locked || bus.err_pulse !== m_pulse || bus.err_count !== CNT_W'(m_count)
                || sat_bus.err_count !== SAT_W'(sat_exp)) begin
                errors++;
                $display("[TB] FAIL random cyc %0d got locked=%0b pulse=%0b cnt=%0d sat=%0d exp %0b/%0b/%0d/%0d",
                         n, bus.locked, bus.err_pulse, bus.err_count, sat_bus.err_count, m_locked, m_pulse, m_count, sat_exp);
            end
        end
    endtask

    task automatic test_saturation_and_clear();
        do_reset();
        repeat (ACQ_BITS) drive(1'b1, 0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            repeat (3) drive(1'b1, 0, 1'b0, 1'b0);
            drive(1'b1, 0, 1'b1, 1'b0);
            checks++;
            if (bus.err_count !== CNT_W'(k) || sat_bus.err_count !== SAT_W'((k > SAT_MAX) ? SAT_MAX : k)) begin
                errors++;
                $display("[TB] FAIL saturate %0d got cnt=%0d sat=%0d exp %0d/%0d",
                         k, bus.err_count, sat_bus.err_count, k, (k > SAT_MAX) ? SAT_MAX : k);
            end
        end
        drive(1'b1, 0, 1'b1, 1'b1);
        checks++;
        if (bus.err_count !== CNT_W'(1) || sat_bus.err_count !== SAT_W'(1) || bus.err_pulse !== 1'b1 || bus.locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_with_err got cnt=%0d sat=%0d pulse=%0b locked=%0b exp 1/1/1/1",
                     bus.err_count, sat_bus.err_count, bus.err_pulse, bus.locked);
        end
        drive(1'b1, 0, 1'b0, 1'b1);
        checks++;
        if (bus.err_count !== '0 || sat_bus.err_count !== '0 || bus.locked !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_plain got cnt=%0d sat=%0d locked=%0b exp 0/0/1", bus.err_count, sat_bus.err_count, bus.locked);
        end
        drive(1'b1, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (bus.err_count !== '0 || bus.err_pulse !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_idle got cnt=%0d pulse=%0b exp 0/0", bus.err_count, bus.err_pulse);
        end
    endtask

    task automatic test_reset_midlock();
        drive(1'b1, 0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== '0 || sat_bus.err_count !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset got locked=%0b pulse=%0b cnt=%0d sat=%0d exp all 0",
                     bus.locked, bus.err_pulse, bus.err_count, sat_bus.err_count);
        end
        do_reset();
        repeat (10) drive(1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_lock got %0b exp 0", bus.locked);
        end
    endtask

    // Bound the whole run so a stuck DUT cannot hang the simulation.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got no finish exp finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.clr_cnt   = 1'b0;
        for (int i = 0; i < 30; i++) hist.push_back(1'b0);
        hist.push_back(1'b1);
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_window_boundary();
        test_const_input();
        test_random_errors();
        test_saturation_and_clear();
        test_reset_midlock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
